// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched
//   SHA-256 message-schedule expander. Loads one 512-bit block as 16
//   32-bit words into a 16-word sliding window, then emits W[0..ROUNDS-1]
//   one word per output handshake, generating W[t+16] as each word leaves.
//
//   Optional build macro: SHA256_SCHED_BSWAP_EN
//     defined   -> in_word is byte-reversed on capture (little-endian feed)
//     undefined -> in_word is captured verbatim (big-endian)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      begin loading a block (honoured only in IDLE)
//   busy       high while loading or emitting
//   in_valid   in_word valid
//   in_ready   block accepts a word (LOAD only)
//   in_word    message word W[0..15], in order
//   out_valid  out_word valid (EMIT only)
//   out_ready  downstream accepts out_word
//   out_word   W[out_idx], straight from the window register
//   out_idx    index t of out_word
//   out_last   high with out_valid when out_idx == ROUNDS-1
//   done       one-cycle pulse the cycle after the last output handshake

module sha256_msg_sched #(
    parameter int unsigned ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [5:0]  out_idx,
    output logic        out_last,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    state_t      state;
    state_t      state_next;
    logic [31:0] win [16];
    logic [3:0]  load_cnt;
    logic [5:0]  t;
    logic        done_r;

    logic        in_fire;
    logic        out_fire;
    logic        final_fire;
    logic [31:0] cap_word;
    logic [31:0] next_word;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

`ifdef SHA256_SCHED_BSWAP_EN
    assign cap_word = {in_word[7:0], in_word[15:8], in_word[23:16], in_word[31:24]};
`else
    assign cap_word = in_word;
`endif

    assign in_fire    = (state == LOAD) && in_valid;
    assign out_fire   = (state == EMIT) && out_ready;
    assign final_fire = out_fire && (t == LAST_IDX);

    // win[0] is W[t]; win[1], win[9], win[14] are W[t+1], W[t+9], W[t+14].
    assign next_word = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: if (in_fire && (load_cnt == 4'd15)) state_next = EMIT;
            EMIT: if (final_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Window, counters and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
            load_cnt <= '0;
            t        <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r <= final_fire;

            if ((state == IDLE) && start) begin
                load_cnt <= '0;
            end

            if (in_fire) begin
                for (int unsigned i = 0; i < 15; i++) begin
                    win[i] <= win[i + 1];
                end
                win[15]  <= cap_word;
                load_cnt <= load_cnt + 4'd1;
                if (load_cnt == 4'd15) begin
                    t <= '0;
                end
            end

            // Surplus words are still generated past ROUNDS-16; they simply
            // never reach win[0] before the block ends.
            if (out_fire) begin
                for (int unsigned i = 0; i < 15; i++) begin
                    win[i] <= win[i + 1];
                end
                win[15] <= next_word;
                t       <= (t == LAST_IDX) ? '0 : t + 6'd1;
            end
        end
    end

    // Outputs
    always_comb begin
        busy      = (state == LOAD) || (state == EMIT);
        in_ready  = (state == LOAD);
        out_valid = (state == EMIT);
        out_word  = win[0];
        out_idx   = t;
        out_last  = (state == EMIT) && (t == LAST_IDX);
        done      = done_r;
    end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb_sha256_msg_sched
//   Scoreboard bench for sha256_msg_sched. The stimulus process loads blocks
//   and pushes the full expected schedule (computed with the textbook SHA-256
//   recurrence over a 64-entry array) into a queue; an independent monitor
//   pops and compares on every output handshake, and also checks output
//   stability under backpressure and the done pulse.

module tb_sha256_msg_sched;

    localparam int ROUNDS = 64;

    typedef struct {
        logic [31:0] word;
        logic [5:0]  idx;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_word = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_word;
    logic [5:0]  out_idx;
    logic        out_last;
    logic        done;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb_q[$];
    logic [31:0] blk [16];
    logic        done_pending = 1'b0;
    logic        stim_done = 1'b0;

    sha256_msg_sched #(.ROUNDS(ROUNDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_word  (in_word),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_word (out_word),
        .out_idx  (out_idx),
        .out_last (out_last),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Reference: full 64-word schedule from the block, then the first ROUNDS.
    task automatic push_expected();
        logic [31:0] w [64];
        exp_t e;
        for (int i = 0; i < 16; i++) w[i] = blk[i];
        for (int i = 16; i < 64; i++) begin
            w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10))
                 + w[i-7]
                 + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3))
                 + w[i-16];
        end
        for (int i = 0; i < ROUNDS; i++) begin
            e.word = w[i];
            e.idx  = 6'(i);
            e.last = (i == ROUNDS - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0]  = 32'h6162_6380;
        blk[15] = 32'h0000_0018;
    endtask

    task automatic set_random();
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_word"},  out_word,       32'd0);
        chk({tag, "_out_idx"},   32'(out_idx),   32'd0);
        chk({tag, "_out_last"},  32'(out_last),  32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
    endtask

    // Entered at posedge+1 in IDLE: issues start and feeds the 16 words.
    task automatic load_block(input bit gaps, input bit rnd_bp);
        int n = 0;
        int cyc = 0;
        start = 1'b1;
        in_valid = 1'b0;
        out_ready = rnd_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (n < 16) begin
            in_valid = gaps ? ((cyc % 2) == 1) : 1'b1;
            `ifdef SHA256_SCHED_BSWAP_EN
            in_word = bswap(blk[n]);
            `else
            in_word = blk[n];
            `endif
            start = (cyc == 4);
            @(negedge clk);
            if (in_valid && in_ready) n++;
            @(posedge clk); #1;
            cyc++;
            if (cyc > 200) begin
                chk("load_timeout", 32'(n), 32'd16);
                in_valid = 1'b0;
                start = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        start = 1'b0;
        in_word = $urandom;
        @(negedge clk);
        chk("emit_first_valid", 32'(out_valid), 32'd1);
        chk("emit_first_idx",   32'(out_idx),   32'd0);
    endtask

    // Runs EMIT. Normal exit: at posedge+1 of the done cycle.
    // Reset exit (rst_at >= 0): at the negedge after the reset cycle.
    task automatic run_emit(input int stall_at, input int rst_at, input bit rnd_bp,
                            output bit aborted);
        int cyc = 0;
        int stall_left = 0;
        bit stalled = 0;
        aborted = 0;
        forever begin
            if (out_valid && out_idx == 6'd10)
                chk("in_ready_in_emit", 32'(in_ready), 32'd0);
            if (out_valid && out_ready && out_last) begin
                @(posedge clk); #1;
                start = 1'b0;
                out_ready = 1'b1;
                return;
            end
            @(posedge clk); #1;
            start = (out_idx == 6'd5);
            if (rst_at >= 0 && out_valid && out_idx == 6'(rst_at)) begin
                rst = 1'b1;
                start = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                sb_q.delete();
                aborted = 1;
                out_ready = 1'b1;
                @(negedge clk);
                check_reset_outputs("mid_emit_reset");
                return;
            end
            if (stall_at >= 0 && !stalled && out_idx == 6'(stall_at)) begin
                stall_left = 5;
                stalled = 1;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = rnd_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            cyc++;
            if (cyc > 1000) begin
                chk("emit_timeout", 32'(out_idx), 32'(ROUNDS - 1));
                start = 1'b0;
                out_ready = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t        e;
        logic        prev_pending = 1'b0;
        logic [31:0] prev_word = '0;
        logic [5:0]  prev_idx = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_pending = 1'b0;
                done_pending = 1'b0;
            end else begin
                if (done_pending) begin
                    chk("done_pulse", 32'(done), 32'd1);
                    done_pending = 1'b0;
                end else if (done) begin
                    chk("done_unexpected", 32'(done), 32'd0);
                end
                if (prev_pending && out_valid) begin
                    chk("hold_word", out_word, prev_word);
                    chk("hold_idx", 32'(out_idx), 32'(prev_idx));
                end
                prev_pending = out_valid && !out_ready;
                prev_word = out_word;
                prev_idx = out_idx;
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_output_idx", 32'(out_idx), 32'hFFFF_FFFF);
                    end else begin
                        e = sb_q.pop_front();
                        checks++;
                        if (out_word !== e.word || out_idx !== e.idx || out_last !== e.last) begin
                            errors++;
                            $display("FAIL out_word: got word=%h idx=%0d last=%0b expected word=%h idx=%0d last=%0b",
                                     out_word, out_idx, out_last, e.word, e.idx, e.last);
                        end
                        if (e.last) done_pending = 1'b1;
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        bit ab;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // in_valid in IDLE must be ignored
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_word = $urandom;
            @(negedge clk);
            chk("idle_in_ready", 32'(in_ready), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;

        // "abc" block, full rate; next start coincides with done
        set_abc();
        push_expected();
        load_block(0, 0);
        run_emit(-1, -1, 0, ab);

        // "abc" block with a 5-cycle stall at t = 20
        push_expected();
        load_block(0, 0);
        run_emit(20, -1, 0, ab);
        idle_cycles(2);

        // "abc" block with gapped input
        push_expected();
        load_block(1, 0);
        run_emit(-1, -1, 0, ab);
        idle_cycles(2);

        // random block, reset at t = 30
        set_random();
        push_expected();
        load_block(0, 0);
        run_emit(-1, 30, 0, ab);
        chk("reset_aborted", 32'(ab), 32'd1);
        @(posedge clk); #1;

        // random blocks, gapped input and random backpressure
        for (int b = 0; b < 4; b++) begin
            set_random();
            push_expected();
            load_block(b[0], 1);
            run_emit(-1, -1, 1, ab);
            idle_cycles(1 + b);
        end

        idle_cycles(3);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        stim_done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
